// File: rtl/dccm_lsu_if.sv
`default_nettype none
// ============================================================================
//  Module      : dccm_lsu_if
//  Description : Core request/response and DCCM port bundle for dccm_lsu.
//                slave  = the load/store unit side.
//                master = the core / memory environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dccm_lsu_if;
  // Core request channel
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  // Core response channel
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  // DCCM word port
  logic        dccm_rd_en;
  logic [31:0] dccm_rd_addr;
  logic [31:0] dccm_rd_data;
  logic        dccm_wr_en;
  logic [31:0] dccm_wr_addr;
  logic [31:0] dccm_wr_data;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    input  dccm_rd_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err,
    output dccm_rd_en, dccm_rd_addr, dccm_wr_en, dccm_wr_addr, dccm_wr_data
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
    output dccm_rd_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err,
    input  dccm_rd_en, dccm_rd_addr, dccm_wr_en, dccm_wr_addr, dccm_wr_data
  );
endinterface
`default_nettype wire

// File: rtl/dccm_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : dccm_lsu
//  Description : Single-outstanding load/store unit in front of a word-only
//                DCCM port. Extracts and extends sub-word loads, performs
//                read-modify-write for sub-word stores, and faults misaligned,
//                illegal-size and out-of-window accesses without touching
//                memory.
//  Revision    : 1.0 - initial release
// ============================================================================
module dccm_lsu #(
  parameter logic [31:0] DCCM_BASE = 32'h0001_0000,
  parameter int          DCCM_AW   = 14
) (
  input  wire logic  clk,
  input  wire logic  rst,
  dccm_lsu_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_LD_WAIT = 2'd1,
    S_RMW     = 2'd2,
    S_RESP    = 2'd3
  } state_t;

  localparam logic [1:0] c_SIZE_BYTE = 2'b00;
  localparam logic [1:0] c_SIZE_HALF = 2'b01;
  localparam logic [1:0] c_SIZE_WORD = 2'b10;
  localparam logic [1:0] c_SIZE_ILL  = 2'b11;

  state_t      state_q, state_d;
  logic [29:0] waddr_q, waddr_d;      // word address held for the RMW write
  logic [1:0]  size_q, size_d;
  logic [1:0]  lane_q, lane_d;
  logic        uns_q, uns_d;
  logic [15:0] wdata_q, wdata_d;      // only the low half matters for sub-word stores
  logic [31:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;

  logic        w_fault;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;
  logic [31:0] w_merged;
  logic        w_rd_en;
  logic        w_wr_en;

  // Access fault detection on the live request (only meaningful in the accept cycle)
  always_comb begin
    w_fault = 1'b0;
    if (bus.req_size == c_SIZE_ILL)                               w_fault = 1'b1;
    if (bus.req_size == c_SIZE_HALF && bus.req_addr[0])           w_fault = 1'b1;
    if (bus.req_size == c_SIZE_WORD && bus.req_addr[1:0] != 2'b00) w_fault = 1'b1;
    if (bus.req_addr[31:DCCM_AW] != DCCM_BASE[31:DCCM_AW])        w_fault = 1'b1;
  end

  // Lane extraction and sign/zero extension of the returned read word
  always_comb begin
    w_byte      = bus.dccm_rd_data[7:0];
    w_half      = bus.dccm_rd_data[15:0];
    w_load_data = bus.dccm_rd_data;
    case (lane_q)
      2'd0:    w_byte = bus.dccm_rd_data[7:0];
      2'd1:    w_byte = bus.dccm_rd_data[15:8];
      2'd2:    w_byte = bus.dccm_rd_data[23:16];
      default: w_byte = bus.dccm_rd_data[31:24];
    endcase
    if (lane_q[1]) w_half = bus.dccm_rd_data[31:16];
    case (size_q)
      c_SIZE_BYTE: w_load_data = {{24{~uns_q & w_byte[7]}}, w_byte};
      c_SIZE_HALF: w_load_data = {{16{~uns_q & w_half[15]}}, w_half};
      default:     w_load_data = bus.dccm_rd_data;
    endcase
  end

  // Merge the latched store data into the word read back for RMW
  always_comb begin
    w_merged = bus.dccm_rd_data;
    if (size_q == c_SIZE_BYTE) begin
      case (lane_q)
        2'd0:    w_merged[7:0]   = wdata_q[7:0];
        2'd1:    w_merged[15:8]  = wdata_q[7:0];
        2'd2:    w_merged[23:16] = wdata_q[7:0];
        default: w_merged[31:24] = wdata_q[7:0];
      endcase
    end else begin
      if (lane_q[1]) w_merged[31:16] = wdata_q;
      else           w_merged[15:0]  = wdata_q;
    end
  end

  // Next-state, request latching and DCCM enable generation
  always_comb begin
    state_d     = state_q;
    waddr_d     = waddr_q;
    size_d      = size_q;
    lane_d      = lane_q;
    uns_d       = uns_q;
    wdata_d     = wdata_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    w_rd_en     = 1'b0;
    w_wr_en     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          if (w_fault) begin
            rsp_err_d   = 1'b1;
            rsp_rdata_d = 32'd0;
            state_d     = S_RESP;
          end else if (!bus.req_we) begin
            w_rd_en = 1'b1;
            size_d  = bus.req_size;
            lane_d  = bus.req_addr[1:0];
            uns_d   = bus.req_unsigned;
            state_d = S_LD_WAIT;
          end else if (bus.req_size == c_SIZE_WORD) begin
            w_wr_en     = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = 32'd0;
            state_d     = S_RESP;
          end else begin
            w_rd_en = 1'b1;
            waddr_d = bus.req_addr[31:2];
            size_d  = bus.req_size;
            lane_d  = bus.req_addr[1:0];
            wdata_d = bus.req_wdata[15:0];
            state_d = S_RMW;
          end
        end
      end
      S_LD_WAIT: begin
        rsp_rdata_d = w_load_data;
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      S_RMW: begin
        w_wr_en     = 1'b1;
        rsp_rdata_d = 32'd0;
        rsp_err_d   = 1'b0;
        state_d     = S_RESP;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // Reset abandons any in-flight access: nothing may reach the DCCM
    if (rst) begin
      w_rd_en = 1'b0;
      w_wr_en = 1'b0;
    end
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      waddr_q     <= 30'd0;
      size_q      <= 2'd0;
      lane_q      <= 2'd0;
      uns_q       <= 1'b0;
      wdata_q     <= 16'd0;
      rsp_rdata_q <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      size_q      <= size_d;
      lane_q      <= lane_d;
      uns_q       <= uns_d;
      wdata_q     <= wdata_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign bus.req_ready    = (state_q == S_IDLE);
  assign bus.rsp_valid    = (state_q == S_RESP) && !rst;
  assign bus.rsp_rdata    = rsp_rdata_q;
  assign bus.rsp_err      = rsp_err_q;
  assign bus.dccm_rd_en   = w_rd_en;
  assign bus.dccm_rd_addr = {bus.req_addr[31:2], 2'b00};
  assign bus.dccm_wr_en   = w_wr_en;
  assign bus.dccm_wr_addr = (state_q == S_RMW) ? {waddr_q, 2'b00} : {bus.req_addr[31:2], 2'b00};
  assign bus.dccm_wr_data = (state_q == S_RMW) ? w_merged : bus.req_wdata;

endmodule
`default_nettype wire

// File: tb/tb_dccm_lsu.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dccm_lsu
//  Description : Self-checking bench for dccm_lsu: DCCM memory model plus a
//                byte-level reference model of the load/store semantics.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dccm_lsu;

  localparam logic [31:0] BASE = 32'h0001_0000;
  localparam int          AW   = 14;
  localparam int          NW   = 1 << (AW - 2);
  localparam logic [31:0] WIN  = 32'd1 << AW;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dccm_lsu_if bus();

  dccm_lsu #(.DCCM_BASE(BASE), .DCCM_AW(AW)) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem     [NW];   // contents of the DCCM as written by the DUT
  logic [31:0] ref_mem [NW];   // what the contents should be
  logic        mem_load = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int n_rd     = 0;
  int n_wr     = 0;
  bit both_seen = 1'b0;
  bit bad_addr  = 1'b0;

  // DCCM model: one-cycle read latency, word writes
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < NW; i++) mem[i] <= ref_mem[i];
    end else begin
      if (bus.dccm_rd_en) bus.dccm_rd_data <= mem[bus.dccm_rd_addr[AW-1:2]];
      if (bus.dccm_wr_en) mem[bus.dccm_wr_addr[AW-1:2]] <= bus.dccm_wr_data;
    end
  end

  // Enable activity monitor
  always @(negedge clk) begin
    if (bus.dccm_rd_en) n_rd++;
    if (bus.dccm_wr_en) n_wr++;
    if (bus.dccm_rd_en && bus.dccm_wr_en) both_seen = 1'b1;
    if (bus.dccm_rd_en && (bus.dccm_rd_addr[1:0] != 2'b00 || bus.dccm_rd_addr[31:AW] != BASE[31:AW])) bad_addr = 1'b1;
    if (bus.dccm_wr_en && (bus.dccm_wr_addr[1:0] != 2'b00 || bus.dccm_wr_addr[31:AW] != BASE[31:AW])) bad_addr = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    bus.req_we       = we;
    bus.req_size     = size;
    bus.req_unsigned = uns;
    bus.req_addr     = addr;
    bus.req_wdata    = wdata;
  endtask

  // Reference model: byte-lane view of memory, updates ref_mem on stores
  task automatic model(input logic we, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output logic [31:0] e_rdata, output logic e_err,
                       output int e_lat, output int e_rd, output int e_wr);
    int          nb, off, idx;
    logic [31:0] w, mask;
    logic [7:0]  b [4];
    nb  = 1 << size;
    off = int'(addr % 4);
    e_err = (size == 2'd3) || ((addr % nb) != 0) || (addr < BASE) || (addr >= BASE + WIN);
    e_rdata = 32'd0;
    if (e_err) begin
      e_lat = 1; e_rd = 0; e_wr = 0;
      return;
    end
    idx = int'((addr - BASE) / 4);
    w   = ref_mem[idx];
    if (!we) begin
      mask    = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      e_rdata = (w >> (8 * off)) & mask;
      if (!uns && nb < 4 && e_rdata[8 * nb - 1]) e_rdata = e_rdata | ~mask;
      e_lat = 2; e_rd = 1; e_wr = 0;
    end else begin
      for (int i = 0; i < 4; i++)  b[i] = w[8 * i +: 8];
      for (int i = 0; i < nb; i++) b[off + i] = wdata[8 * i +: 8];
      ref_mem[idx] = {b[3], b[2], b[1], b[0]};
      e_lat = (nb == 4) ? 1 : 2;
      e_rd  = (nb == 4) ? 0 : 1;
      e_wr  = 1;
    end
  endtask

  // One request from IDLE to response; entered and left at posedge+1
  task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] obs_rdata, output logic obs_err);
    logic [31:0] e_rdata;
    logic        e_err;
    int          e_lat, e_rd, e_wr, rd0, wr0, lat, idx;
    model(we, size, uns, addr, wdata, e_rdata, e_err, e_lat, e_rd, e_wr);
    drive_req(we, size, uns, addr, wdata);
    bus.req_valid = 1'b1;
    rd0 = n_rd;
    wr0 = n_wr;
    sample();
    chk("accept_ready", bus.req_ready, 1);
    chk("idle_no_rsp", bus.rsp_valid, 0);
    chk("accept_rd_en", bus.dccm_rd_en, e_rd);
    chk("accept_wr_en", bus.dccm_wr_en, (e_wr == 1 && e_lat == 1) ? 1 : 0);
    if (e_rd == 1) chk("accept_rd_addr", bus.dccm_rd_addr, {addr[31:2], 2'b00});
    if (e_wr == 1 && e_lat == 1) begin
      chk("accept_wr_addr", bus.dccm_wr_addr, {addr[31:2], 2'b00});
      chk("accept_wr_data", bus.dccm_wr_data, wdata);
    end
    step();
    bus.req_valid = 1'b0;
    drive_req($urandom_range(0, 1) == 1, 2'($urandom_range(0, 3)), 1'b0, $urandom, $urandom);
    lat       = 0;
    obs_rdata = 32'hx;
    obs_err   = 1'bx;
    for (int c = 1; c <= 4 && lat == 0; c++) begin
      sample();
      if (bus.rsp_valid) begin
        lat       = c;
        obs_rdata = bus.rsp_rdata;
        obs_err   = bus.rsp_err;
      end
      step();
    end
    chk("rsp_latency", lat, e_lat);
    chk("rsp_err", obs_err, e_err);
    chk("rsp_rdata", obs_rdata, e_rdata);
    chk("dccm_reads", n_rd - rd0, e_rd);
    chk("dccm_writes", n_wr - wr0, e_wr);
    if (we && !e_err) begin
      idx = int'((addr - BASE) / 4);
      chk("mem_word", mem[idx], ref_mem[idx]);
    end
  endtask

  // Four requests with req_valid held high throughout
  task automatic back_to_back();
    logic        we_a [4];
    logic [1:0]  sz_a [4];
    logic        un_a [4];
    logic [31:0] ad_a [4];
    logic [31:0] wd_a [4];
    logic [31:0] qd [$];
    logic        qe [$];
    logic [31:0] er;
    logic        ee;
    int          el, erd, ewr, k, nresp;
    bit          just;
    we_a[0] = 1; sz_a[0] = 2; un_a[0] = 0; ad_a[0] = BASE + 32'h50; wd_a[0] = $urandom;
    we_a[1] = 0; sz_a[1] = 0; un_a[1] = 1; ad_a[1] = BASE + 32'h51; wd_a[1] = $urandom;
    we_a[2] = 1; sz_a[2] = 1; un_a[2] = 0; ad_a[2] = BASE + 32'h52; wd_a[2] = $urandom;
    we_a[3] = 0; sz_a[3] = 2; un_a[3] = 0; ad_a[3] = BASE + 32'h50; wd_a[3] = $urandom;
    k = 0; nresp = 0; just = 0;
    drive_req(we_a[0], sz_a[0], un_a[0], ad_a[0], wd_a[0]);
    bus.req_valid = 1'b1;
    for (int c = 0; c < 40 && nresp < 4; c++) begin
      sample();
      if (bus.rsp_valid) begin
        chk("b2b_rsp_expected", (qd.size() > 0) ? 1 : 0, 1);
        if (qd.size() > 0) begin
          chk("b2b_rdata", bus.rsp_rdata, qd.pop_front());
          chk("b2b_err", bus.rsp_err, qe.pop_front());
        end
        nresp++;
      end
      if (just) begin
        chk("b2b_ready_low", bus.req_ready, 0);
        just = 0;
      end else if (bus.req_ready && k < 4) begin
        model(we_a[k], sz_a[k], un_a[k], ad_a[k], wd_a[k], er, ee, el, erd, ewr);
        qd.push_back(er);
        qe.push_back(ee);
        k++;
        just = 1;
      end
      step();
      if (k < 4) drive_req(we_a[k], sz_a[k], un_a[k], ad_a[k], wd_a[k]);
      else       bus.req_valid = 1'b0;
    end
    bus.req_valid = 1'b0;
    chk("b2b_accepts", k, 4);
    chk("b2b_responses", nresp, 4);
  endtask

  // Sub-word store hit by reset in its RMW cycle
  task automatic reset_mid_rmw();
    int idx;
    idx = int'(32'h40 / 4);
    drive_req(1'b1, 2'd0, 1'b0, BASE + 32'h41, 32'h0000_0055);
    bus.req_valid = 1'b1;
    sample();
    chk("rmwrst_rd_en", bus.dccm_rd_en, 1);
    step();
    bus.req_valid = 1'b0;
    rst = 1'b1;
    sample();
    chk("rmwrst_no_wr", bus.dccm_wr_en, 0);
    chk("rmwrst_no_rsp", bus.rsp_valid, 0);
    step();
    rst = 1'b0;
    sample();
    chk("rmwrst_ready", bus.req_ready, 1);
    chk("rmwrst_no_rsp_after", bus.rsp_valid, 0);
    chk("rmwrst_mem", mem[idx], ref_mem[idx]);
    step();
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    logic        we;
    logic [1:0]  sz;
    logic [31:0] ad;

    bus.req_valid = 1'b0;
    drive_req(1'b0, 2'd0, 1'b0, 32'd0, 32'd0);
    for (int i = 0; i < NW; i++) ref_mem[i] = $urandom;
    mem_load = 1'b1;
    step();
    mem_load = 1'b0;

    // Reset behaviour
    step();
    sample();
    chk("rst_rd_en", bus.dccm_rd_en, 0);
    chk("rst_wr_en", bus.dccm_wr_en, 0);
    chk("rst_rsp_valid", bus.rsp_valid, 0);
    step();
    rst = 1'b0;
    sample();
    chk("rst_rsp_rdata", bus.rsp_rdata, 0);
    chk("rst_rsp_err", bus.rsp_err, 0);
    chk("rst_req_ready", bus.req_ready, 1);
    step();

    // Word store then load
    do_req(1'b1, 2'd2, 1'b0, 32'h0001_0010, 32'hDEAD_BEEF, rd, er);
    chk("sw_mem_const", mem[4], 32'hDEAD_BEEF);
    do_req(1'b0, 2'd2, 1'b0, 32'h0001_0010, 32'h0, rd, er);
    chk("lw_const", rd, 32'hDEAD_BEEF);

    // Sub-word loads
    do_req(1'b1, 2'd2, 1'b0, 32'h0001_0020, 32'h80FF_7F01, rd, er);
    do_req(1'b0, 2'd0, 1'b0, 32'h0001_0023, 32'h0, rd, er);
    chk("lb_const", rd, 32'hFFFF_FF80);
    do_req(1'b0, 2'd0, 1'b1, 32'h0001_0023, 32'h0, rd, er);
    chk("lbu_const", rd, 32'h0000_0080);
    do_req(1'b0, 2'd1, 1'b0, 32'h0001_0022, 32'h0, rd, er);
    chk("lh_const", rd, 32'hFFFF_80FF);
    do_req(1'b0, 2'd1, 1'b1, 32'h0001_0020, 32'h0, rd, er);
    chk("lhu_const", rd, 32'h0000_7F01);

    // Read-modify-write stores
    do_req(1'b1, 2'd2, 1'b0, 32'h0001_0030, 32'h1122_3344, rd, er);
    do_req(1'b1, 2'd0, 1'b0, 32'h0001_0031, 32'h0000_00AA, rd, er);
    chk("sb_mem_const", mem[12], 32'h1122_AA44);
    do_req(1'b1, 2'd1, 1'b0, 32'h0001_0032, 32'h0000_BBCC, rd, er);
    chk("sh_mem_const", mem[12], 32'hBBCC_AA44);

    // Faults
    do_req(1'b0, 2'd2, 1'b0, 32'h0001_0002, 32'h0, rd, er);
    chk("fault_lw_mis", er, 1);
    do_req(1'b1, 2'd1, 1'b0, 32'h0001_0001, 32'h1234, rd, er);
    chk("fault_sh_mis", er, 1);
    do_req(1'b0, 2'd3, 1'b0, 32'h0001_0000, 32'h0, rd, er);
    chk("fault_size11", er, 1);
    do_req(1'b0, 2'd2, 1'b0, 32'h0002_0000, 32'h0, rd, er);
    chk("fault_range", er, 1);

    back_to_back();
    reset_mid_rmw();

    // Randomized traffic concentrated on a small window to create aliasing
    for (int n = 0; n < 200; n++) begin
      we = ($urandom_range(0, 1) == 1);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 15) == 0) ad = $urandom;
      else                            ad = BASE + 32'($urandom_range(0, 127));
      do_req(we, sz, ($urandom_range(0, 1) == 1), ad, $urandom, rd, er);
    end

    chk("no_simultaneous_rd_wr", both_seen, 0);
    chk("dccm_addr_legal", bad_addr, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dccm_lsu.md
Name: dccm_lsu

Overview:
- Load/store unit sitting directly upstream of the DCCM port of the closely-coupled memory block.
- Accepts one core load/store request at a time and drives the word-wide DCCM read/write ports.
- Performs byte/halfword lane extraction with sign or zero extension on loads.
- Performs read-modify-write for sub-word stores, because the DCCM write port is word-only with no byte enables.
- Flags misaligned, illegal-size and out-of-range accesses without touching memory.

Parameters:
- DCCM_BASE, 32'h0001_0000, byte base address of the DCCM window; must be aligned to 2**DCCM_AW.
- DCCM_AW, 14, log2 of the DCCM window size in bytes (default 16 KB).

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-high.
- req_valid  input  1  core request valid.
- req_ready  output  1  unit can accept a request.
- req_we  input  1  1 = store, 0 = load.
- req_size  input  2  00 = byte, 01 = half, 10 = word, 11 = illegal.
- req_unsigned  input  1  load zero-extends when 1, sign-extends when 0.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-justified.
- rsp_valid  output  1  one-cycle response pulse.
- rsp_rdata  output  32  load result (0 for stores and errors).
- rsp_err  output  1  access fault.
- dccm_rd_en  output  1  DCCM read enable.
- dccm_rd_addr  output  32  word-aligned read address.
- dccm_rd_data  input  32  DCCM read data, valid the cycle after dccm_rd_en.
- dccm_wr_en  output  1  DCCM write enable.
- dccm_wr_addr  output  32  word-aligned write address.
- dccm_wr_data  output  32  full word to write.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (rst).
- Reset values: state IDLE; rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - dccm_rd_en and dccm_wr_en are 0 during any cycle with rst = 1.
  - Reset mid-operation abandons the request: no write is issued and no response is produced.
- States:
  - IDLE: req_ready = 1. An accept happens when req_valid = 1 in IDLE.
  - LD_WAIT: capture dccm_rd_data, extract and extend into the rsp_rdata register, go to RESP.
  - RMW: drive dccm_wr_en = 1 with dccm_wr_addr = latched word address and dccm_wr_data = merged word, go to RESP.
  - RESP: rsp_valid = 1 for exactly one cycle, req_ready = 0, go to IDLE.
- Fault checks, all evaluated in the accept cycle; fault when any holds:
  - req_size = 11.
  - req_size = 01 and req_addr[0] = 1.
  - req_size = 10 and req_addr[1:0] != 0.
  - req_addr[31:DCCM_AW] != DCCM_BASE[31:DCCM_AW].
  - Fault action: no DCCM enable asserted, go to RESP with rsp_err = 1 and rsp_rdata = 0.
- Accept-cycle DCCM drives are combinational from the request; addresses are {req_addr[31:2], 2'b00}.
  - Load: dccm_rd_en = 1, go to LD_WAIT.
  - Word store: dccm_wr_en = 1, dccm_wr_data = req_wdata, go to RESP.
  - Sub-word store: dccm_rd_en = 1, latch address, size, lane and data, go to RMW.
- Latency from accept to rsp_valid: fault 1 cycle; word store 1 cycle; load 2 cycles; sub-word store 2 cycles. Minimum request spacing is 2 or 3 cycles respectively.
- Load extraction:
  - Byte lane = addr[1:0]; half lane = addr[1].
  - Extend from bit 7 (byte) or bit 15 (half) when req_unsigned = 0; zero-extend otherwise. Word loads pass through.
- RMW merge: replace byte addr[1:0] with wdata[7:0], or half addr[1] with wdata[15:0]; all other bytes keep the value read.
- Store responses: rsp_rdata = 0, rsp_err = 0.
- Outputs outside the cases above:
  - dccm_rd_en and dccm_wr_en are 0 in every other cycle.
  - Address and data outputs are don't-care when their enable is 0.
  - rsp_err and rsp_rdata hold their last values while rsp_valid = 0.
- Response backpressure: none. The consumer must take rsp_valid when it pulses.
- Concurrency: only one request is in flight, so no read/write hazard exists inside the unit.
- Simultaneous DCCM read and write is never issued.

Test Plan:
- Word store then load: store 0xDEADBEEF to 0x0001_0010 → dccm_wr_en in the accept cycle, rsp_valid next cycle. Load word from 0x0001_0010 → rsp_rdata = 0xDEADBEEF, 2 cycles after accept, rsp_err = 0.
- Sub-word loads: memory word 0x80FF_7F01 at 0x0001_0020.
  - lb at +3 → 0xFFFF_FF80; lbu at +3 → 0x0000_0080.
  - lh at +2 → 0xFFFF_80FF; lhu at +0 → 0x0000_7F01.
- RMW: memory 0x1122_3344.
  - sb 0xAA at +1 → exactly one read, then one write of 0x1122_AA44, rsp 2 cycles after accept.
  - Then sh 0xBBCC at +2 → 0xBBCC_AA44.
- Faults, each with no DCCM enable, rsp_err = 1, rsp 1 cycle after accept:
  - lw at 0x0001_0002; sh at 0x0001_0001; size = 11.
  - Address 0x0002_0000 with DCCM_AW = 14.
- Back-to-back: req_valid held high across 4 requests → req_ready low in non-IDLE states, each request accepted once, responses in order.
- Reset mid-RMW: assert rst in the RMW cycle → no dccm_wr_en, no rsp_valid, next cycle IDLE with req_ready = 1 and memory unchanged.
